// File: rtl/hazard_scoreboard_if.sv
// Issue-control bundle between the S1 regfile stage and the hazard scoreboard.
// The pipeline drives the S1 lane contents; the scoreboard returns hold/bubble controls.
interface hazard_scoreboard_if #(
  parameter int LANES = 2,
  parameter int REGW  = 3,
  parameter int CNTW  = 16
);
  logic [LANES-1:0]        s1_valid;
  logic [LANES*3*REGW-1:0] s1_readnums;
  logic [LANES*3-1:0]      s1_used;
  logic [LANES-1:0]        s1_write;
  logic [LANES*REGW-1:0]   s1_writenum;
  logic [LANES-1:0]        s1_is_ld;
  logic [LANES-1:0]        s1_is_st;
  logic                    flush;
  logic [LANES-1:0]        update1_out;
  logic [LANES-1:0]        rst_s1_out;
  logic [LANES-1:0]        rst_s2_out;
  logic                    fetch_next;
  logic [CNTW-1:0]         stall_ld_cnt;
  logic [CNTW-1:0]         stall_dep_cnt;

  modport master (
    output s1_valid, s1_readnums, s1_used, s1_write,
    output s1_writenum, s1_is_ld, s1_is_st, flush,
    input  update1_out, rst_s1_out, rst_s2_out,
    input  fetch_next, stall_ld_cnt, stall_dep_cnt
  );

  modport slave (
    input  s1_valid, s1_readnums, s1_used, s1_write,
    input  s1_writenum, s1_is_ld, s1_is_st, flush,
    output update1_out, rst_s1_out, rst_s2_out,
    output fetch_next, stall_ld_cnt, stall_dep_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// N-lane in-order issue hazard control with a per-register pending-load scoreboard.
// Drives S1 hold, S1/S2 bubbles, fetch_next, and saturating stall counters.
module hazard_scoreboard #(
  parameter int LANES  = 2,
  parameter int NREG   = 8,
  parameter int REGW   = 3,
  parameter int LD_LAT = 2,
  parameter int CNTW   = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int SW = 3 * REGW;
  localparam int NR = 1 << REGW;

  logic [2:0]      r_cnt [NREG];
  logic [2:0]      w_nxt [NREG];
  logic [NR-1:0]   w_pend;
  logic [REGW-1:0] w_src [LANES][3];
  logic [LANES-1:0] w_blk_ld;
  logic [LANES-1:0] w_blk_dep;
  logic [LANES-1:0] w_blk;
  logic [LANES-1:0] w_pre;
  logic [LANES-1:0] w_issue;
  logic            w_seen;
  logic            w_ld_br;
  logic            w_stall_ld;
  logic            w_stall_dep;
  logic [CNTW-1:0] r_ld_cnt;
  logic [CNTW-1:0] r_dep_cnt;

  // Pending map, widened to the full index space so any source index is safe.
  always_comb begin
    w_pend = '0;
    for (int r = 0; r < NREG; r++)
      w_pend[r] = (r_cnt[r] != 3'd0);
  end

  // Unpack per-lane sources: slot 0 = Rd, 1 = Rn, 2 = Rm.
  always_comb begin
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < 3; s++)
        w_src[l][s] = bus.s1_readnums[l*SW + s*REGW +: REGW];
  end

  // Per-lane load-use and intra-bundle dependency blocks.
  always_comb begin
    w_blk_ld  = '0;
    w_blk_dep = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < 3; s++)
        if (bus.s1_used[l*3+s] && w_pend[w_src[l][s]])
          w_blk_ld[l] = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        if (k < l && bus.s1_valid[k]) begin
          if (bus.s1_write[k])
            for (int s = 0; s < 3; s++)
              if (bus.s1_used[l*3+s] &&
                  bus.s1_writenum[k*REGW +: REGW] == w_src[l][s])
                w_blk_dep[l] = 1'b1;
          if (bus.s1_is_st[l] && bus.s1_is_ld[k])
            w_blk_dep[l] = 1'b1;
        end
      end
      w_blk_ld[l]  = w_blk_ld[l]  & bus.s1_valid[l];
      w_blk_dep[l] = w_blk_dep[l] & bus.s1_valid[l];
    end
    w_blk = w_blk_ld | w_blk_dep;
  end

  // Find the first blocking lane; w_pre marks lanes in the issuable prefix.
  always_comb begin
    w_seen  = 1'b0;
    w_ld_br = 1'b0;
    w_pre   = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pre[l] = !w_seen && !w_blk[l];
      if (!w_seen && w_blk[l]) begin
        w_seen  = 1'b1;
        w_ld_br = w_blk_ld[l];
      end
    end
    w_stall_ld  = !bus.flush && w_seen && w_ld_br;
    w_stall_dep = !bus.flush && w_seen && !w_ld_br;
    w_issue = '0;
    if (!bus.flush && !w_stall_ld)
      w_issue = bus.s1_valid & w_pre;
  end

  // Pipeline control outputs; flush overrides every stall branch.
  always_comb begin
    bus.update1_out = '1;
    bus.rst_s1_out  = '0;
    bus.rst_s2_out  = '0;
    bus.fetch_next  = 1'b1;
    if (bus.flush) begin
      bus.rst_s1_out = '1;
      bus.rst_s2_out = '1;
    end else if (w_stall_ld) begin
      bus.update1_out = '0;
      bus.rst_s2_out  = '1;
      bus.fetch_next  = 1'b0;
    end else if (w_stall_dep) begin
      bus.update1_out = w_pre;
      bus.rst_s1_out  = w_pre;
      bus.rst_s2_out  = ~w_pre;
      bus.fetch_next  = 1'b0;
    end
  end

  // Next scoreboard: decrement, kill loads caught in S2 on flush, then set/clear.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_nxt[r] = (r_cnt[r] != 3'd0) ? r_cnt[r] - 3'd1 : 3'd0;
      if (bus.flush && r_cnt[r] == 3'(LD_LAT))
        w_nxt[r] = 3'd0;
      for (int l = 0; l < LANES; l++)
        if (w_issue[l] && bus.s1_write[l] &&
            bus.s1_writenum[l*REGW +: REGW] == REGW'(r))
          w_nxt[r] = bus.s1_is_ld[l] ? 3'(LD_LAT) : 3'd0;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        r_cnt[r] <= 3'd0;
    end else begin
      for (int r = 0; r < NREG; r++)
        r_cnt[r] <= w_nxt[r];
    end
  end

  // Saturating stall performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ld_cnt  <= '0;
      r_dep_cnt <= '0;
    end else begin
      if (w_stall_ld && r_ld_cnt != '1)
        r_ld_cnt <= r_ld_cnt + 1'b1;
      if (w_stall_dep && r_dep_cnt != '1)
        r_dep_cnt <= r_dep_cnt + 1'b1;
    end
  end

  assign bus.stall_ld_cnt  = r_ld_cnt;
  assign bus.stall_dep_cnt = r_dep_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard, LANES=2, LD_LAT=2, CNTW=4.
// Each scenario task drives vectors and checks hand-computed values.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  hazard_scoreboard_if #(.LANES(2), .REGW(3), .CNTW(4)) bus ();

  hazard_scoreboard #(
    .LANES(2), .NREG(8), .REGW(3), .LD_LAT(2), .CNTW(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_bus();
    bus.s1_valid    = '0;
    bus.s1_readnums = '0;
    bus.s1_used     = '0;
    bus.s1_write    = '0;
    bus.s1_writenum = '0;
    bus.s1_is_ld    = '0;
    bus.s1_is_st    = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_lane(input int l, input logic v,
                          input logic [2:0] rm, input logic [2:0] rn,
                          input logic [2:0] rd, input logic [2:0] used,
                          input logic wr, input logic [2:0] wn,
                          input logic ld, input logic st);
    bus.s1_valid[l]          = v;
    bus.s1_readnums[l*9 +: 9] = {rm, rn, rd};
    bus.s1_used[l*3 +: 3]     = used;
    bus.s1_write[l]          = wr;
    bus.s1_writenum[l*3 +: 3] = wn;
    bus.s1_is_ld[l]          = ld;
    bus.s1_is_st[l]          = st;
  endtask

  task automatic do_reset();
    clr_bus();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (bus.update1_out !== 2'b11) begin
      $display("FAIL rst_upd got %b exp 11", bus.update1_out); n_fail++;
    end
    n_chk++;
    if (bus.rst_s1_out !== 2'b00 || bus.rst_s2_out !== 2'b00) begin
      $display("FAIL rst_bub got %b/%b exp 00/00",
               bus.rst_s1_out, bus.rst_s2_out); n_fail++;
    end
    n_chk++;
    if (bus.fetch_next !== 1'b1) begin
      $display("FAIL rst_fetch got %b exp 1", bus.fetch_next); n_fail++;
    end
    n_chk++;
    if (bus.stall_ld_cnt !== 4'd0 || bus.stall_dep_cnt !== 4'd0) begin
      $display("FAIL rst_cnt got %0d/%0d exp 0/0",
               bus.stall_ld_cnt, bus.stall_dep_cnt); n_fail++;
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lane(0, 1, 3'd0, 3'd0, 3'd0, 3'b000, 1, 3'd3, 1, 0);
    #1;
    n_chk++;
    if (bus.fetch_next !== 1'b1 || bus.update1_out !== 2'b11) begin
      $display("FAIL lu_c0 got f=%b u=%b exp 1/11",
               bus.fetch_next, bus.update1_out); n_fail++;
    end
    step();
    set_lane(0, 1, 3'd0, 3'd3, 3'd0, 3'b010, 1, 3'd4, 0, 0);
    for (int c = 1; c <= 2; c++) begin
      #1;
      n_chk++;
      if (bus.update1_out !== 2'b00 || bus.rst_s2_out !== 2'b11 ||
          bus.rst_s1_out !== 2'b00 || bus.fetch_next !== 1'b0) begin
        $display("FAIL lu_stall c%0d got u=%b s1=%b s2=%b f=%b exp 00/00/11/0",
                 c, bus.update1_out, bus.rst_s1_out, bus.rst_s2_out,
                 bus.fetch_next); n_fail++;
      end
      step();
    end
    n_chk++;
    if (bus.update1_out !== 2'b11 || bus.fetch_next !== 1'b1) begin
      $display("FAIL lu_c3 got u=%b f=%b exp 11/1",
               bus.update1_out, bus.fetch_next); n_fail++;
    end
    step();
    n_chk++;
    if (bus.stall_ld_cnt !== 4'd2) begin
      $display("FAIL lu_cnt got %0d exp 2", bus.stall_ld_cnt); n_fail++;
    end
  endtask

  task automatic test_dep();
    do_reset();
    set_lane(0, 1, 3'd0, 3'd0, 3'd0, 3'b000, 1, 3'd2, 0, 0);
    set_lane(1, 1, 3'd2, 3'd0, 3'd0, 3'b100, 1, 3'd5, 0, 0);
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b01 || bus.rst_s1_out !== 2'b01 ||
        bus.rst_s2_out !== 2'b10 || bus.fetch_next !== 1'b0) begin
      $display("FAIL dep_part got u=%b s1=%b s2=%b f=%b exp 01/01/10/0",
               bus.update1_out, bus.rst_s1_out, bus.rst_s2_out,
               bus.fetch_next); n_fail++;
    end
    step();
    set_lane(0, 0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 3'd0, 0, 0);
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b11 || bus.rst_s1_out !== 2'b00 ||
        bus.fetch_next !== 1'b1) begin
      $display("FAIL dep_rest got u=%b s1=%b f=%b exp 11/00/1",
               bus.update1_out, bus.rst_s1_out, bus.fetch_next); n_fail++;
    end
    step();
    n_chk++;
    if (bus.stall_dep_cnt !== 4'd1 || bus.stall_ld_cnt !== 4'd0) begin
      $display("FAIL dep_cnt got %0d/%0d exp 1/0",
               bus.stall_dep_cnt, bus.stall_ld_cnt); n_fail++;
    end
  endtask

  task automatic test_ld_st();
    do_reset();
    set_lane(0, 1, 3'd0, 3'd6, 3'd0, 3'b010, 1, 3'd1, 1, 0);
    set_lane(1, 1, 3'd0, 3'd7, 3'd5, 3'b011, 0, 3'd0, 0, 1);
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b01 || bus.rst_s1_out !== 2'b01 ||
        bus.rst_s2_out !== 2'b10 || bus.fetch_next !== 1'b0) begin
      $display("FAIL ldst_part got u=%b s1=%b s2=%b f=%b exp 01/01/10/0",
               bus.update1_out, bus.rst_s1_out, bus.rst_s2_out,
               bus.fetch_next); n_fail++;
    end
    step();
    set_lane(0, 0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 3'd0, 0, 0);
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b11 || bus.fetch_next !== 1'b1) begin
      $display("FAIL ldst_st got u=%b f=%b exp 11/1",
               bus.update1_out, bus.fetch_next); n_fail++;
    end
    step();
    set_lane(1, 1, 3'd0, 3'd1, 3'd0, 3'b010, 1, 3'd2, 0, 0);
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b00 || bus.fetch_next !== 1'b0) begin
      $display("FAIL ldst_r1use got u=%b f=%b exp 00/0",
               bus.update1_out, bus.fetch_next); n_fail++;
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_lane(0, 1, 3'd0, 3'd0, 3'd0, 3'b000, 1, 3'd4, 1, 0);
    step();
    set_lane(0, 1, 3'd4, 3'd0, 3'd0, 3'b100, 1, 3'd6, 0, 0);
    bus.flush = 1'b1;
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b11 || bus.rst_s1_out !== 2'b11 ||
        bus.rst_s2_out !== 2'b11 || bus.fetch_next !== 1'b1) begin
      $display("FAIL flush_out got u=%b s1=%b s2=%b f=%b exp 11/11/11/1",
               bus.update1_out, bus.rst_s1_out, bus.rst_s2_out,
               bus.fetch_next); n_fail++;
    end
    step();
    bus.flush = 1'b0;
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b11 || bus.fetch_next !== 1'b1) begin
      $display("FAIL flush_after got u=%b f=%b exp 11/1",
               bus.update1_out, bus.fetch_next); n_fail++;
    end
    step();
    n_chk++;
    if (bus.stall_ld_cnt !== 4'd0 || bus.stall_dep_cnt !== 4'd0) begin
      $display("FAIL flush_cnt got %0d/%0d exp 0/0",
               bus.stall_ld_cnt, bus.stall_dep_cnt); n_fail++;
    end
  endtask

  task automatic test_same_dest();
    do_reset();
    set_lane(0, 1, 3'd0, 3'd0, 3'd0, 3'b000, 1, 3'd5, 1, 0);
    set_lane(1, 1, 3'd6, 3'd7, 3'd0, 3'b110, 1, 3'd5, 0, 0);
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b11 || bus.fetch_next !== 1'b1) begin
      $display("FAIL same_iss got u=%b f=%b exp 11/1",
               bus.update1_out, bus.fetch_next); n_fail++;
    end
    step();
    set_lane(0, 1, 3'd5, 3'd0, 3'd0, 3'b100, 1, 3'd6, 0, 0);
    set_lane(1, 0, 3'd0, 3'd0, 3'd0, 3'b000, 0, 3'd0, 0, 0);
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b11 || bus.fetch_next !== 1'b1) begin
      $display("FAIL same_use got u=%b f=%b exp 11/1",
               bus.update1_out, bus.fetch_next); n_fail++;
    end
  endtask

  task automatic test_saturate();
    do_reset();
    set_lane(0, 1, 3'd0, 3'd3, 3'd0, 3'b010, 1, 3'd3, 1, 0);
    for (int c = 0; c < 40; c++)
      step();
    n_chk++;
    if (bus.stall_ld_cnt !== 4'hF) begin
      $display("FAIL sat_cnt got %h exp f", bus.stall_ld_cnt); n_fail++;
    end
    do_reset();
    n_chk++;
    if (bus.stall_ld_cnt !== 4'd0 || bus.stall_dep_cnt !== 4'd0) begin
      $display("FAIL sat_rst got %0d/%0d exp 0/0",
               bus.stall_ld_cnt, bus.stall_dep_cnt); n_fail++;
    end
    set_lane(0, 1, 3'd0, 3'd3, 3'd0, 3'b010, 1, 3'd2, 0, 0);
    #1;
    n_chk++;
    if (bus.update1_out !== 2'b11 || bus.fetch_next !== 1'b1) begin
      $display("FAIL sat_sbclr got u=%b f=%b exp 11/1",
               bus.update1_out, bus.fetch_next); n_fail++;
    end
  endtask

  initial begin
    clr_bus();
    step();
    test_reset();
    test_load_use();
    test_dep();
    test_ld_st();
    test_flush();
    test_same_dest();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the dual-pipe hazard control unit: N-lane in-order issue, configurable register file size and load-to-use latency.
- Per-register pending-load scoreboard with countdown replaces the fixed S2/S3 load-destination comparators.
- Sits at the S1 (REGFILE) stage. Drives per-lane S1 hold, S1/S2 bubble injection and fetch_next.
- Adds pipeline flush and saturating stall performance counters.

Parameters:
- LANES, 2, issue lanes; lane 0 is oldest.
- NREG, 8, architectural registers.
- REGW, 3, register index width; must be at least clog2(NREG).
- LD_LAT, 2, cycles after load issue before its data is forwardable (1..7).
- CNTW, 16, performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- s1_valid  in  LANES  lane holds a real instruction in S1.
- s1_readnums  in  LANES*3*REGW  per lane {Rm,Rn,Rd}; lane l at [(l+1)*3*REGW-1 : l*3*REGW].
- s1_used  in  LANES*3  per lane {Rm,Rn,Rd} source-used mask.
- s1_write  in  LANES  lane writes a register.
- s1_writenum  in  LANES*REGW  destination register per lane.
- s1_is_ld  in  LANES  lane is LDR.
- s1_is_st  in  LANES  lane is STR.
- flush  in  1  kill S1 and S2 contents this cycle.
- update1_out  out  LANES  high: lane's S1 register may load new contents.
- rst_s1_out  out  LANES  high: clear lane's S1 slot to a bubble.
- rst_s2_out  out  LANES  high: insert a bubble into lane's S2.
- fetch_next  out  1  S0 may advance / fetch a new bundle.
- stall_ld_cnt  out  CNTW  cycles with a load-use stall.
- stall_dep_cnt  out  CNTW  cycles with an intra-bundle partial issue.

Behaviour:
- Scoreboard:
  - cnt[r] is 3 bits, one per register.
  - Register r is "pending" while cnt[r] != 0.
  - Each edge, every nonzero cnt decrements.
- Scoreboard set/clear rules:
  - An issuing lane with s1_write loads cnt[writenum] with LD_LAT if s1_is_ld, else 0.
  - The set/clear overrides the decrement.
  - Several issuing lanes with the same writenum: the highest (youngest) lane wins.
- LD_LAT=2 meaning: a consumer in S1 is blocked while the load is in S2 or S3, and issues once the load reaches S4.
- Per-lane readiness:
  - blk_ld[l]: s1_valid[l], and any used source of lane l is pending.
  - blk_dep[l]: s1_valid[l], and either:
    - some older valid lane k<l has s1_write with writenum equal to a used source of l; or
    - s1_is_st[l] and some older valid lane k has s1_is_ld[k].
- Issue mask:
  - The issue mask is the longest prefix 0..j-1 of lanes that are invalid or unblocked.
  - Invalid lanes count as issued and do not break the prefix.
- Outputs when blk_ld is set in the first blocking lane (includes lane 0):
  - update1_out = 0 for all lanes.
  - rst_s2_out = 1 for all lanes.
  - rst_s1_out = 0.
  - fetch_next = 0.
- Outputs when the first blocking lane j has only blk_dep:
  - Lanes < j: update1_out = 1, rst_s1_out = 1 (issued lanes vacate S1).
  - Lanes >= j: update1_out = 0, rst_s2_out = 1.
  - fetch_next = 0.
- Outputs when no lane is blocked:
  - update1_out all 1; rst_s1_out and rst_s2_out 0; fetch_next = 1.
- Scoreboard update uses only issued lanes.
  - A lane with rst_s1_out=1 is invalid next cycle, so it never re-issues.
- Flush, same cycle:
  - update1_out all 1; rst_s1_out all 1; rst_s2_out all 1; fetch_next = 1.
  - No lane issues and counters do not increment.
  - Every cnt equal to LD_LAT is cleared (those loads are in S2 and killed); all other cnt decrement normally.
- Performance counters:
  - stall_ld_cnt increments on cycles taking the load-use stall branch.
  - stall_dep_cnt increments on cycles taking the intra-bundle partial-issue branch.
  - Both saturate at all-ones and do not wrap.
- All outputs are combinational from inputs and scoreboard state; there is no added latency.
- Reset (rst_n=0 at an edge):
  - All cnt = 0 and both perf counters = 0.
  - Combinational outputs take the no-block values while s1_valid = 0.
  - Reset mid-stall discards all pending loads.
- A lane with s1_valid=0 never blocks, never sets the scoreboard, and is ignored as an older producer.

Test Plan:
- LANES=2, LD_LAT=2: lane0 LDR r3 issues at cycle 0; cycle 1 lane0 ADD uses Rn=r3 -> cycles 1-2 all update1_out=0, rst_s2_out=2'b11, fetch_next=0; cycle 3 issues; stall_ld_cnt=2.
- Lane0 MOV writes r2, lane1 uses Rm=r2, no pending -> update1_out=2'b01, rst_s1_out=2'b01, rst_s2_out=2'b10, fetch_next=0. Next cycle lane0 invalid, lane1 issues, fetch_next=1; stall_dep_cnt=1.
- Lane0 LDR r1, lane1 STR (unrelated registers) -> partial issue as above. Next cycle lane1 is not blocked (cnt[r1]=2 only affects r1 users).
- Load r4 issues, next cycle flush=1 -> cnt[4] cleared; following cycle a consumer of r4 issues immediately; rst_s1_out=rst_s2_out=2'b11 during flush.
- Lane0 LDR r5 and lane1 ADD r5 issue together -> cnt[5]=0; a consumer of r5 next cycle is not stalled.
- Force 2^CNTW+3 load-use stall cycles (CNTW=4) -> stall_ld_cnt holds 4'hF. Then rst_n=0 for 1 edge -> counters 0 and all cnt 0.
